hood_mode_ctrl: RTL
===================

// Module: hood_mode_ctrl
// PURPOSE
//  Parametrised range-hood mode controller; supersedes the fixed 2-level FSM.
//  Supports N manual fan levels, a timed boost level, a timed drain-down after boost abort,
//  timed self-clean, and a saturating fan-usage second counter that a completed clean clears.
//  Sits between the debounced button layer and the fan/LED/display drivers.
// PARAMETERS
//  CLK_HZ     100_000_000  clk cycles per second (prescaler terminal count)
//  N_LEVELS   2            manual fan levels, 1..8; boost level = N_LEVELS+1
//  BOOST_SEC  60           boost run time, s (>=1)
//  DRAIN_SEC  60           drain time at level N_LEVELS after boost abort, s (>=1)
//  CLEAN_SEC  180          self-clean run time, s (>=1)
//  TW         16           width of remaining_sec; must hold max(*_SEC)
// PORTS
//  clk            in   1           system clock
//  rst            in   1           asynchronous reset, active-high
//  power_on       in   1           machine on/off level
//  menu_btn       in   1           debounced level; rising edge detected internally
//  level_btn      in   N_LEVELS    level_btn[i] selects manual level i+1
//  boost_btn      in   1           request boost
//  clean_btn      in   1           request self-clean
//  boost_enable   in   1           boost permitted (one-shot policy is upstream)
//  mode_state     out  3           0 OFF,1 STANDBY,2 LEVEL,3 BOOST,4 DRAIN,5 CLEAN
//  fan_level      out  4           0 off/standby/clean, 1..N_LEVELS manual, N_LEVELS+1 boost
//  led            out  N_LEVELS+3  one-hot {clean,boost,level N..1,standby}; DRAIN lights level N; all 0 in OFF
//  remaining_sec  out  TW          seconds left in BOOST/DRAIN/CLEAN, else 0
//  usage_sec      out  32          cumulative seconds with fan_level!=0, saturating
//  boost_done     out  1           1-cycle pulse when BOOST is left by any path, incl. power-off
// BEHAVIOUR
//  - Reset: state OFF; all outputs 0; menu_armed=0; both prescalers 0. No stored power_on history.
//  - power_on=0: from any state go OFF next cycle, disarm, clear state timer; usage_sec held.
//  - OFF & power_on=1 -> STANDBY.
//  - menu_edge = menu_btn & ~menu_btn_q. In STANDBY, menu_edge toggles menu_armed.
//  - STANDBY & armed, priority: lowest-index level_btn -> LEVEL i+1; else boost_btn&boost_enable -> BOOST;
//    else clean_btn -> CLEAN. boost_btn with boost_enable=0 ignored, stays armed. Entry clears menu_armed.
//  - LEVEL k: menu_edge -> STANDBY (wins over same-cycle level_btn); else lowest-index level_btn[j],
//    j+1!=k -> LEVEL j+1; else hold. boost/clean buttons ignored.
//  - BOOST: timed BOOST_SEC; expiry -> LEVEL N_LEVELS; menu_edge -> DRAIN (wins over same-cycle expiry).
//  - DRAIN: timed DRAIN_SEC at fan_level N_LEVELS; expiry -> STANDBY; all buttons ignored.
//  - CLEAN: timed CLEAN_SEC, fan_level 0; expiry -> STANDBY and usage_sec<=0 same edge; buttons ignored.
//    Power-off abort of CLEAN does not clear usage_sec.
//  - State timer: on every entry to a timed state prescaler<=0, remaining_sec<=duration. tick when
//    prescaler==CLK_HZ-1 (prescaler wraps to 0). On tick remaining_sec-=1; tick with remaining_sec==1
//    is expiry, and the state changes on that edge. Exit is exactly duration*CLK_HZ cycles after entry edge.
//  - Usage: free-running second prescaler counts only while fan_level!=0, holds otherwise.
//    At its wrap usage_sec+=1, saturating at 32'hFFFF_FFFF.
//  - Outputs: all registered; mode_state/fan_level/led/remaining_sec update on the transition edge,
//    no extra latency.
//  - boost_done: asserted on the edge leaving BOOST (expiry, menu_edge or power-off), low otherwise.
//  - Async rst mid-countdown: all outputs 0 immediately, in the same cycle as rst.
// TESTING (CLK_HZ=4, N_LEVELS=3, BOOST_SEC=3, DRAIN_SEC=2, CLEAN_SEC=5)
//  1 power_on=1, menu edge, level_btn=3'b110 -> LEVEL 2, fan_level=2, led=6'b000100; next level_btn=3'b001 -> LEVEL 1.
//  2 STANDBY armed, boost_btn, boost_enable=1 -> BOOST, remaining 3,2,1 at 4-cycle steps;
//    after 12 cycles -> LEVEL 3, boost_done 1 cycle.
//  3 BOOST, menu_edge at cycle 5 -> DRAIN, fan_level=3, remaining=2; STANDBY 8 cycles later.
//    Repeat with menu_edge on the expiry edge -> DRAIN.
//  4 usage_sec=7 after LEVEL run, then CLEAN -> fan_level 0, usage held; 20 cycles later STANDBY, usage_sec=0.
//    Variant: power_on=0 mid-CLEAN -> OFF, usage_sec stays 7.
//  5 rst pulse mid-BOOST -> all outputs 0 immediately, state OFF; release with power_on=1 -> STANDBY, menu_armed=0.
//  6 Armed STANDBY, boost_btn with boost_enable=0 -> stays STANDBY armed; menu edge in LEVEL with
//    simultaneous level_btn -> STANDBY.

Source files
------------

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood mode controller.
// Manages OFF/STANDBY/manual LEVEL/timed BOOST/timed DRAIN/timed CLEAN modes,
// drives registered fan level, LED and countdown outputs, and keeps a
// saturating count of seconds the fan has been running.
module hood_mode_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int N_LEVELS  = 2,
    parameter int BOOST_SEC = 60,
    parameter int DRAIN_SEC = 60,
    parameter int CLEAN_SEC = 180,
    parameter int TW        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                power_on,
    input  logic                menu_btn,
    input  logic [N_LEVELS-1:0] level_btn,
    input  logic                boost_btn,
    input  logic                clean_btn,
    input  logic                boost_enable,
    output logic [2:0]          mode_state,
    output logic [3:0]          fan_level,
    output logic [N_LEVELS+2:0] led,
    output logic [TW-1:0]       remaining_sec,
    output logic [31:0]         usage_sec,
    output logic                boost_done
);

    localparam int            PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST    = PW'(CLK_HZ - 1);
    localparam logic [TW-1:0] BOOST_T     = TW'(BOOST_SEC);
    localparam logic [TW-1:0] DRAIN_T     = TW'(DRAIN_SEC);
    localparam logic [TW-1:0] CLEAN_T     = TW'(CLEAN_SEC);
    localparam logic [3:0]    TOP_LEVEL   = 4'(N_LEVELS);
    localparam logic [3:0]    BOOST_LEVEL = 4'(N_LEVELS + 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_STANDBY = 3'd1,
        S_LEVEL   = 3'd2,
        S_BOOST   = 3'd3,
        S_DRAIN   = 3'd4,
        S_CLEAN   = 3'd5
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  menu_armed;
    logic                  next_armed;
    logic                  menu_btn_q;
    logic                  menu_edge;
    logic [PW-1:0]         state_pre;
    logic [PW-1:0]         next_pre;
    logic [PW-1:0]         usage_pre;
    logic [TW-1:0]         next_remaining;
    logic [3:0]            next_manual;
    logic [3:0]            next_fan;
    logic [N_LEVELS+2:0]   next_led;
    logic                  next_boost_done;
    logic                  timed_now;
    logic                  tick;
    logic                  expire;
    logic                  clear_usage;
    logic                  lvl_any;
    logic [3:0]            lvl_sel;
    logic                  other_any;
    logic [3:0]            other_sel;
    logic                  usage_wrap;

    assign mode_state = state;
    assign menu_edge  = menu_btn & ~menu_btn_q;
    assign timed_now  = (state == S_BOOST) || (state == S_DRAIN) || (state == S_CLEAN);
    assign tick       = timed_now && (state_pre == PRE_LAST);
    assign expire     = tick && (remaining_sec == TW'(1));
    assign usage_wrap = (fan_level != 4'd0) && (usage_pre == PRE_LAST);

    // Lowest-index pressed level button, overall and excluding the level already running
    always_comb begin
        lvl_any   = 1'b0;
        lvl_sel   = 4'd0;
        other_any = 1'b0;
        other_sel = 4'd0;
        for (int i = N_LEVELS - 1; i >= 0; i--) begin
            if (level_btn[i]) begin
                lvl_any = 1'b1;
                lvl_sel = 4'(i + 1);
            end
            if (level_btn[i] && (4'(i + 1) != fan_level)) begin
                other_any = 1'b1;
                other_sel = 4'(i + 1);
            end
        end
    end

    // Next mode, arming, state timer and the registered output values for the next cycle
    always_comb begin
        next_state      = state;
        next_armed      = menu_armed;
        next_manual     = fan_level;
        clear_usage     = 1'b0;
        next_pre        = '0;
        next_remaining  = '0;
        next_fan        = 4'd0;
        next_led        = '0;
        next_boost_done = 1'b0;

        if (!power_on) begin
            next_state = S_OFF;
            next_armed = 1'b0;
        end else begin
            case (state)
                S_OFF: next_state = S_STANDBY;
                S_STANDBY: begin
                    if (menu_armed && lvl_any) begin
                        next_state  = S_LEVEL;
                        next_manual = lvl_sel;
                        next_armed  = 1'b0;
                    end else if (menu_armed && boost_btn && boost_enable) begin
                        next_state = S_BOOST;
                        next_armed = 1'b0;
                    end else if (menu_armed && clean_btn) begin
                        next_state = S_CLEAN;
                        next_armed = 1'b0;
                    end else if (menu_edge) begin
                        next_armed = ~menu_armed;
                    end
                end
                S_LEVEL: begin
                    if (menu_edge) begin
                        next_state = S_STANDBY;
                    end else if (other_any) begin
                        next_manual = other_sel;
                    end
                end
                S_BOOST: begin
                    if (menu_edge) begin
                        next_state = S_DRAIN;
                    end else if (expire) begin
                        next_state  = S_LEVEL;
                        next_manual = TOP_LEVEL;
                    end
                end
                S_DRAIN: begin
                    if (expire) begin
                        next_state = S_STANDBY;
                    end
                end
                S_CLEAN: begin
                    if (expire) begin
                        next_state  = S_STANDBY;
                        clear_usage = 1'b1;
                    end
                end
                default: next_state = S_OFF;
            endcase
        end

        if ((next_state == S_BOOST) || (next_state == S_DRAIN) || (next_state == S_CLEAN)) begin
            if (next_state != state) begin
                next_pre = '0;
                case (next_state)
                    S_BOOST: next_remaining = BOOST_T;
                    S_DRAIN: next_remaining = DRAIN_T;
                    default: next_remaining = CLEAN_T;
                endcase
            end else begin
                next_pre       = tick ? '0 : state_pre + PW'(1);
                next_remaining = tick ? remaining_sec - TW'(1) : remaining_sec;
            end
        end

        case (next_state)
            S_STANDBY: next_led[0] = 1'b1;
            S_LEVEL: begin
                next_fan = next_manual;
                for (int i = 1; i <= N_LEVELS; i++) begin
                    if (next_manual == 4'(i)) begin
                        next_led[i] = 1'b1;
                    end
                end
            end
            S_BOOST: begin
                next_fan                = BOOST_LEVEL;
                next_led[N_LEVELS + 1]  = 1'b1;
            end
            S_DRAIN: begin
                next_fan           = TOP_LEVEL;
                next_led[N_LEVELS] = 1'b1;
            end
            S_CLEAN: next_led[N_LEVELS + 2] = 1'b1;
            default: ;
        endcase

        next_boost_done = (state == S_BOOST) && (next_state != S_BOOST);
    end

    // Mode register and all mode-dependent registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_OFF;
            menu_armed    <= 1'b0;
            menu_btn_q    <= 1'b0;
            state_pre     <= '0;
            remaining_sec <= '0;
            fan_level     <= 4'd0;
            led           <= '0;
            boost_done    <= 1'b0;
        end else begin
            state         <= next_state;
            menu_armed    <= next_armed;
            menu_btn_q    <= menu_btn;
            state_pre     <= next_pre;
            remaining_sec <= next_remaining;
            fan_level     <= next_fan;
            led           <= next_led;
            boost_done    <= next_boost_done;
        end
    end

    // Fan-usage seconds: prescaler runs only while the fan spins, a finished clean zeroes the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            usage_pre <= '0;
            usage_sec <= 32'd0;
        end else begin
            if (fan_level != 4'd0) begin
                usage_pre <= usage_wrap ? '0 : usage_pre + PW'(1);
            end
            if (clear_usage) begin
                usage_sec <= 32'd0;
            end else if (usage_wrap && (usage_sec != 32'hFFFF_FFFF)) begin
                usage_sec <= usage_sec + 32'd1;
            end
        end
    end

endmodule
